// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared entry record, link states and result-latency encoding for hazard_tracker
package mips_hazard_pkg;
  localparam int RDY_W = 8;
  localparam logic [4:0] ZERO = 5'd0;
  typedef struct packed {
    logic valid;
    logic [4:0] waddr;
    logic [RDY_W-1:0] ready;
  } entry_t;
  typedef enum logic {UNLINKED, LINKED} link_state_t;
  function automatic logic [RDY_W-1:0] ready_of(input logic is_load, input logic is_mul,
                                                input int load_ready, input int mul_ready);
    return is_mul ? RDY_W'(mul_ready) : is_load ? RDY_W'(load_ready) : '0;
  endfunction
endpackage

// File: rtl/hazard_fwd_select.sv
// hazard_fwd_select: youngest-writer match for one source operand, forwarding mux and hazard flag
module hazard_fwd_select
  import mips_hazard_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_STAGES = 3
) (
  input  entry_t [NUM_STAGES-1:0]    entries,
  input  logic [4:0]                 src,
  input  logic [XLEN-1:0]            rf_data,
  input  logic [NUM_STAGES*XLEN-1:0] stage_data,
  output logic [XLEN-1:0]            data,
  output logic                       hazard
);
  // scan oldest to youngest so the youngest matching writer overrides older ones
  always_comb begin
    data = rf_data;
    hazard = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].waddr == src && src != ZERO) begin
        data = stage_data[i*XLEN +: XLEN];
        hazard = RDY_W'(i) < entries[i].ready;
      end
    end
  end
endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: in-flight writer tracking, operand forwarding, interlock and LL/SC link state (optional link FSM: HAZARD_TRACKER_LLSC_EN)
module hazard_tracker
  import mips_hazard_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 1,
  parameter int MUL_READY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [4:0]                 id_rs_addr,
  input  logic [4:0]                 id_rt_addr,
  input  logic                       id_reads_rs,
  input  logic                       id_reads_rt,
  input  logic                       id_we,
  input  logic [4:0]                 id_waddr,
  input  logic                       id_is_load,
  input  logic                       id_is_mul,
  input  logic                       id_is_ll,
  input  logic                       id_is_sc,
  input  logic                       id_is_store,
  input  logic [XLEN-1:0]            rs_data_in,
  input  logic [XLEN-1:0]            rt_data_in,
  input  logic [NUM_STAGES*XLEN-1:0] stage_data,
  input  logic                       link_clear,
  output logic [XLEN-1:0]            rs_data,
  output logic [XLEN-1:0]            rt_data,
  output logic                       stall,
  output logic                       atomic_id,
  output logic                       mem_sc_mask_id
);
  entry_t [NUM_STAGES-1:0] ent;
  entry_t new_e;
  logic rs_hazard, rt_hazard, issue;
  assign stall = id_valid & ((id_reads_rs & rs_hazard) | (id_reads_rt & rt_hazard));
  assign issue = id_valid & ~stall;
  assign new_e = '{valid: issue & id_we & (id_waddr != ZERO), waddr: id_waddr,
                   ready: ready_of(id_is_load, id_is_mul, LOAD_READY, MUL_READY)};
  // records advance every cycle, even while ID is stalled, so stalls always drain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ent <= '0;
    else ent <= {ent[NUM_STAGES-2:0], new_e};
  hazard_fwd_select #(.XLEN(XLEN), .NUM_STAGES(NUM_STAGES)) u_rs (
    .entries(ent), .src(id_rs_addr), .rf_data(rs_data_in), .stage_data(stage_data),
    .data(rs_data), .hazard(rs_hazard)
  );
  hazard_fwd_select #(.XLEN(XLEN), .NUM_STAGES(NUM_STAGES)) u_rt (
    .entries(ent), .src(id_rt_addr), .rf_data(rt_data_in), .stage_data(stage_data),
    .data(rt_data), .hazard(rt_hazard)
  );
`ifdef HAZARD_TRACKER_LLSC_EN
  link_state_t state, state_nxt;
  // link state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= UNLINKED;
    else state <= state_nxt;
  // link_clear beats a same-cycle LL; an issued SC or store breaks the link
  always_comb begin
    state_nxt = link_clear ? UNLINKED :
                (issue & id_is_ll) ? LINKED :
                (issue & (id_is_sc | id_is_store)) ? UNLINKED : state;
  end
  assign atomic_id = state == LINKED;
  assign mem_sc_mask_id = id_is_sc & ~atomic_id;
`else
  logic unused_link;
  assign unused_link = ^{link_clear, id_is_ll, id_is_sc, id_is_store};
  assign atomic_id = 1'b0;
  assign mem_sc_mask_id = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed vector table, reset corner cases and randomized checks against an issue-history model
module tb_hazard_tracker;
  localparam int XLEN = 32;
  localparam int NS = 3;
  localparam int LOAD_READY = 1;
  localparam int MUL_READY = 2;
`ifdef HAZARD_TRACKER_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_reads_rs, id_reads_rt, id_we, id_is_load, id_is_mul, id_is_ll, id_is_sc, id_is_store, link_clear;
  logic [4:0] id_rs_addr, id_rt_addr, id_waddr;
  logic [XLEN-1:0] rs_data_in, rt_data_in, rs_data, rt_data;
  logic [NS*XLEN-1:0] stage_data;
  logic stall, atomic_id, mem_sc_mask_id;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  hazard_tracker #(.XLEN(XLEN), .NUM_STAGES(NS), .LOAD_READY(LOAD_READY), .MUL_READY(MUL_READY)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_reads_rs(id_reads_rs), .id_reads_rt(id_reads_rt), .id_we(id_we), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .id_is_mul(id_is_mul), .id_is_ll(id_is_ll), .id_is_sc(id_is_sc),
    .id_is_store(id_is_store), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .stage_data(stage_data),
    .link_clear(link_clear), .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .atomic_id(atomic_id),
    .mem_sc_mask_id(mem_sc_mask_id)
  );

  typedef struct {
    bit v; logic [4:0] rs, rt; bit rrs, rrt, we; logic [4:0] wa;
    bit ld, mul, ll, sc, st, lc; logic [31:0] d0;
    bit e_stall, chk; logic [31:0] e_rs, e_rt; bit e_at, e_mask;
  } vec_t;
  vec_t tbl[22];

  typedef struct { int cyc; logic [4:0] wa; int lat; } rec_t;
  rec_t q[$];
  int cyc;
  bit linked;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t r);
    id_valid = r.v; id_rs_addr = r.rs; id_rt_addr = r.rt; id_reads_rs = r.rrs; id_reads_rt = r.rrt;
    id_we = r.we; id_waddr = r.wa; id_is_load = r.ld; id_is_mul = r.mul; id_is_ll = r.ll;
    id_is_sc = r.sc; id_is_store = r.st; link_clear = r.lc;
    rs_data_in = 32'h1111; rt_data_in = 32'h2222;
    stage_data = {32'hB, 32'h5555, r.d0};
  endtask

  // youngest in-flight writer of src: an instruction issued at cycle c sits in stage cyc-c-1
  function automatic void lookup(input logic [4:0] src, input logic [31:0] rf,
                                 output logic [31:0] d, output bit haz);
    int best = NS, lat = 0;
    foreach (q[k]) begin
      int s = cyc - q[k].cyc - 1;
      if (src != 0 && q[k].wa == src && s >= 0 && s < best) begin best = s; lat = q[k].lat; end
    end
    d = (best < NS) ? stage_data[best*XLEN +: XLEN] : rf;
    haz = (best < NS) && (best < lat);
  endfunction

  initial begin
    vec_t r;
    logic [31:0] ers, ert;
    bit hrs, hrt, est;
    tbl[0]  = '{1,1,2,1,1,1,3,0,0,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[1]  = '{1,3,3,1,1,1,4,0,0,0,0,0,0,32'h1234,0,1,32'h1234,32'h1234,0,0};
    tbl[2]  = '{1,1,0,1,0,1,5,1,0,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[3]  = '{1,5,0,1,1,1,6,0,0,0,0,0,0,32'h1234,1,0,0,0,0,0};
    tbl[4]  = '{1,5,0,1,1,1,6,0,0,0,0,0,0,32'h1234,0,1,32'h5555,32'h2222,0,0};
    tbl[5]  = '{1,1,2,1,1,1,6,0,1,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[6]  = '{1,6,1,1,1,1,7,0,0,0,0,0,0,32'h1234,1,0,0,0,0,0};
    tbl[7]  = '{1,6,1,1,1,1,7,0,0,0,0,0,0,32'h1234,1,0,0,0,0,0};
    tbl[8]  = '{1,6,1,1,1,1,7,0,0,0,0,0,0,32'h1234,0,1,32'hB,32'h2222,0,0};
    tbl[9]  = '{1,1,1,1,1,1,8,0,0,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[10] = '{1,1,1,1,1,1,7,0,0,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[11] = '{1,7,0,1,1,1,9,0,0,0,0,0,0,32'hA,0,1,32'hA,32'h2222,0,0};
    tbl[12] = '{1,1,1,1,1,1,0,0,0,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[13] = '{1,0,0,1,1,1,10,0,0,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[14] = '{1,1,2,1,0,1,11,1,0,1,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[15] = '{1,1,2,1,1,1,12,0,0,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,1,0};
    tbl[16] = '{1,1,2,1,1,1,13,0,0,0,1,0,0,32'h1234,0,1,32'h1111,32'h2222,1,0};
    tbl[17] = '{1,1,2,1,0,1,11,1,0,1,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[18] = '{1,1,2,1,1,0,0,0,0,0,0,1,0,32'h1234,0,1,32'h1111,32'h2222,1,0};
    tbl[19] = '{1,1,2,1,1,1,13,0,0,0,1,0,0,32'h1234,0,1,32'h1111,32'h2222,0,1};
    tbl[20] = '{1,1,2,1,0,1,11,1,0,1,0,0,1,32'h1234,0,1,32'h1111,32'h2222,0,0};
    tbl[21] = '{1,1,2,1,1,1,12,0,0,0,0,0,0,32'h1234,0,1,32'h1111,32'h2222,0,0};

    // reset state with a dependent-looking instruction in ID
    apply(tbl[1]);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_atomic", {31'b0, atomic_id}, 32'd0);
    chk("reset_mask", {31'b0, mem_sc_mask_id}, 32'd0);
    chk("reset_rs", rs_data, 32'h1111);
    chk("reset_rt", rt_data, 32'h2222);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_rs", i), rs_data, tbl[i].e_rs);
        chk($sformatf("row%0d_rt", i), rt_data, tbl[i].e_rt);
      end
      chk($sformatf("row%0d_atomic", i), {31'b0, atomic_id}, {31'b0, tbl[i].e_at & LLSC});
      chk($sformatf("row%0d_mask", i), {31'b0, mem_sc_mask_id}, {31'b0, tbl[i].e_mask & LLSC});
      @(negedge clk);
    end

    // reset asserted during a load-use stall while linked
    apply('{1,1,2,1,0,1,5,1,0,1,0,0,0,32'h1234,0,1,0,0,0,0});
    @(negedge clk);
    apply('{1,5,0,1,1,1,6,0,0,0,0,0,0,32'h1234,0,1,0,0,0,0});
    #1;
    chk("midrst_stall_before", {31'b0, stall}, 32'd1);
    chk("midrst_atomic_before", {31'b0, atomic_id}, {31'b0, LLSC});
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_stall_async", {31'b0, stall}, 32'd0);
    chk("midrst_atomic_async", {31'b0, atomic_id}, 32'd0);
    chk("midrst_rs_async", rs_data, 32'h1111);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);

    // randomized run against the issue-history model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); cyc = 0; linked = 1'b0; est = 1'b0;
    r = tbl[0];
    for (int n = 0; n < 600; n++) begin
      if (!est) begin
        int cls;
        cls = $urandom_range(0, 5);
        r.v = $urandom_range(0, 9) != 0;
        r.rs = 5'($urandom_range(0, 7)); r.rt = 5'($urandom_range(0, 7));
        r.rrs = 1'($urandom); r.rrt = 1'($urandom);
        r.wa = 5'($urandom_range(0, 7));
        r.ld = cls == 1 || cls == 3; r.mul = cls == 2; r.ll = cls == 3;
        r.sc = cls == 4; r.st = cls == 5;
        r.we = cls != 5 && $urandom_range(0, 7) != 0;
      end
      r.lc = $urandom_range(0, 19) == 0;
      apply(r);
      rs_data_in = $urandom; rt_data_in = $urandom;
      stage_data = {$urandom, $urandom, $urandom};
      #1;
      lookup(r.rs, rs_data_in, ers, hrs);
      lookup(r.rt, rt_data_in, ert, hrt);
      est = r.v && ((r.rrs && hrs) || (r.rrt && hrt));
      chk("rnd_stall", {31'b0, stall}, {31'b0, est});
      if (!hrs) chk("rnd_rs", rs_data, ers);
      if (!hrt) chk("rnd_rt", rt_data, ert);
      chk("rnd_atomic", {31'b0, atomic_id}, {31'b0, LLSC & linked});
      chk("rnd_mask", {31'b0, mem_sc_mask_id}, {31'b0, LLSC & r.sc & ~linked});
      @(posedge clk);
      if (r.v && !est && r.we && r.wa != 0)
        q.push_back('{cyc, r.wa, r.mul ? MUL_READY : r.ld ? LOAD_READY : 0});
      if (r.lc) linked = 1'b0;
      else if (r.v && !est && r.ll) linked = 1'b1;
      else if (r.v && !est && (r.sc || r.st)) linked = 1'b0;
      cyc++;
      while (q.size() > 0 && cyc - q[0].cyc - 1 >= NS) void'(q.pop_front());
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
